// File: rtl/mcast_pkg.sv
// ============================================================================
// Module  : mcast_pkg
// Brief   : Shared FSM state type and width helpers for the tag multicaster.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mcast_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } mcast_state_e;

    localparam int c_kernel_w = 8;
    localparam int c_stall_w  = 16;

    // A single-endpoint bus still needs a 1-bit tag.
    function automatic int mcast_id_w(input int num_col);
        return (num_col > 1) ? $clog2(num_col) : 1;
    endfunction

    function automatic int mcast_psum_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mcast_fifo.sv
// ============================================================================
// Module  : mcast_fifo
// Brief   : Synchronous FIFO with registered storage and 0-cycle head read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mcast_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int             c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_depth);
    assign empty  = (r_count == '0);
    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;
    assign rdata  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/tag_multicaster.sv
// ============================================================================
// Module  : tag_multicaster
// Brief   : Per-PE multicast endpoint: tag-filtered bus beats into a FIFO
//           toward the PE, PE psums back to the bus, one window per pass.
//           Optional MCAST_STALL_CNT_EN builds a saturating stall counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_multicaster
    import mcast_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_COL    = 4,
    parameter  int FIFO_DEPTH = 2,
    localparam int ID_W       = mcast_id_w(NUM_COL),
    localparam int PSUM_W     = mcast_psum_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_W-1:0]       cfg_id,
    input  logic [c_kernel_w-1:0] kernel_size,
    input  logic                  flush,
    input  logic                  bus_valid,
    output logic                  bus_ready,
    input  logic [ID_W-1:0]       bus_tag,
    input  logic [DATA_WIDTH-1:0] bus_ifmap,
    input  logic [DATA_WIDTH-1:0] bus_fltr,
    input  logic [PSUM_W-1:0]     bus_psum,
    output logic                  pe_en,
    output logic                  pe_valid,
    input  logic                  pe_ready,
    output logic [DATA_WIDTH-1:0] pe_ifmap,
    output logic [DATA_WIDTH-1:0] pe_fltr,
    output logic [PSUM_W-1:0]     pe_psum,
    output logic [c_kernel_w-1:0] pe_kernel_size,
    input  logic                  ret_valid,
    output logic                  ret_ready,
    input  logic [PSUM_W-1:0]     ret_psum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PSUM_W-1:0]     out_psum,
    output logic [ID_W-1:0]       out_tag,
    output logic                  window_done,
    output logic [c_stall_w-1:0]  stall_cnt
);

    localparam int c_beat_w = 4 * DATA_WIDTH;

    mcast_state_e          r_state;
    mcast_state_e          w_state_nxt;
    logic [c_kernel_w-1:0] r_cnt;
    logic [c_kernel_w-1:0] w_cnt_nxt;
    logic [c_kernel_w-1:0] r_kernel;
    logic [c_kernel_w-1:0] w_kernel_nxt;
    logic                  w_done_nxt;
    logic                  r_pe_en;
    logic                  r_window_done;
    logic                  r_out_valid;
    logic [PSUM_W-1:0]     r_out_psum;
    logic                  w_match;
    logic                  w_bus_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_ret_ready;
    logic [c_beat_w-1:0]   w_head;

    // Non-matching beats are always taken (dropped) so endpoints can AND readies.
    assign w_match     = bus_valid && (bus_tag == cfg_id);
    assign w_bus_ready = !w_match || ((r_state != DRAIN) && !w_full);
    assign w_push      = w_match && w_bus_ready;
    assign w_pop       = !w_empty && pe_ready;
    assign w_ret_ready = !r_out_valid || out_ready;

    mcast_fifo #(
        .WIDTH (c_beat_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({bus_ifmap, bus_fltr, bus_psum}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_kernel_nxt = r_kernel;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_kernel_nxt = kernel_size;
                    w_cnt_nxt    = c_kernel_w'(1);
                    w_state_nxt  = (kernel_size == c_kernel_w'(1)) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                // A zero kernel never closes; only flush leaves STREAM.
                if (w_push) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if ((r_kernel != '0) && (w_cnt_nxt == r_kernel)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_empty && !r_out_valid) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_kernel      <= '0;
            r_pe_en       <= 1'b0;
            r_window_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_kernel      <= w_kernel_nxt;
            r_pe_en       <= (w_state_nxt != IDLE);
            r_window_done <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_out_valid <= 1'b0;
            r_out_psum  <= '0;
        end else if (ret_valid && w_ret_ready) begin
            r_out_valid <= 1'b1;
            r_out_psum  <= ret_psum;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MCAST_STALL_CNT_EN
    logic [c_stall_w-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_stall_cnt <= '0;
        end else if (w_match && !w_bus_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

    assign bus_ready      = w_bus_ready;
    assign ret_ready      = w_ret_ready;
    assign pe_valid       = !w_empty;
    assign {pe_ifmap, pe_fltr, pe_psum} = w_head;
    assign pe_en          = r_pe_en;
    assign pe_kernel_size = r_kernel;
    assign out_valid      = r_out_valid;
    assign out_psum       = r_out_psum;
    assign out_tag        = cfg_id;
    assign window_done    = r_window_done;

endmodule

`default_nettype wire
